// File: rtl/dnn_mem_responder.sv
// dnn_mem_responder: word-addressed SRAM model for one DNN memory port.
// Fixed response latency; bench preload port; DNN_MEM_ADDR_CHECK_EN enables the address check.
module dnn_mem_responder #(
    parameter int          DEPTH   = 16384,
    parameter logic [31:0] BASE    = 32'h0000_0000,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    input  logic        ld_en,
    input  logic [31:0] ld_idx,
    input  logic [31:0] ld_data,
    output logic        err
);

    localparam int LAT = (LATENCY < 1) ? 1 : LATENCY;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            lat_write;
    logic [31:0]     lat_addr;
    logic [31:0]     lat_wdata;

    logic [31:0]     mem [DEPTH];

    logic            go_resp;
    logic            c_write;
    logic [31:0]     c_addr;
    logic [31:0]     c_wdata;
    logic [31:0]     full_idx;
    logic [AW-1:0]   idx;
    logic            bad;

    // With LATENCY 1 the commit happens on the acceptance edge, so the live
    // request is used; otherwise the latched copy is.
    always_comb begin
        c_write = lat_write;
        c_addr  = lat_addr;
        c_wdata = lat_wdata;
        go_resp = 1'b0;
        if (state == IDLE) begin
            c_write = mem_write;
            c_addr  = mem_addr;
            c_wdata = mem_wdata;
            go_resp = mem_valid && (LAT == 1);
        end else if (state == WAIT) begin
            go_resp = (cnt == CW'(1));
        end
    end

    assign full_idx = (c_addr - BASE) >> 2;
    assign idx      = full_idx[AW-1:0];

`ifdef DNN_MEM_ADDR_CHECK_EN
    assign bad = (c_addr < BASE) || (full_idx >= 32'(DEPTH)) || (c_addr[1:0] != 2'b00);
    logic unused_bits;
    assign unused_bits = ^{ld_idx};
`else
    assign bad = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{full_idx, c_addr[1:0], ld_idx};
`endif

    // Array writes: preload first so a same-edge protocol write to the same word wins.
    always_ff @(posedge clk) begin
        if (ld_en)
            mem[ld_idx[AW-1:0]] <= ld_data;
        if (!reset && go_resp && c_write && !bad)
            mem[idx] <= c_wdata;
    end

    // Request FSM, response pulse, read data register and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            err       <= 1'b0;
        end else begin
            mem_ready <= go_resp;
            unique case (state)
                IDLE: begin
                    if (mem_valid) begin
                        lat_write <= mem_write;
                        lat_addr  <= mem_addr;
                        lat_wdata <= mem_wdata;
                        cnt       <= CW'(LAT - 1);
                        state     <= (LAT == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= RESP;
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
            if (go_resp) begin
                if (!c_write)
                    mem_rdata <= bad ? 32'h0000_0000 : mem[idx];
                if (bad)
                    err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dnn_mem_responder.sv
// tb_dnn_mem_responder: randomized scoreboard bench for dnn_mem_responder.
// Builds with or without DNN_MEM_ADDR_CHECK_EN; the reference model follows the macro.
module tb_dnn_mem_responder;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          LAT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        ld_en;
    logic [31:0] ld_idx;
    logic [31:0] ld_data;
    logic        err;

    dnn_mem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .ld_en     (ld_en),
        .ld_idx    (ld_idx),
        .ld_data   (ld_data),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_ready = 0;
    bit          in_resp = 0;
    bit          prev_ready = 0;

    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_rd = 32'h0;
    logic        m_err = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: the transaction outcome from the address rules.
    task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output exp_t e);
        logic [31:0] off;
        int          i;
        bit          illegal;
        off = a - BASE;
        i   = int'((off >> 2) % DEPTH);
`ifdef DNN_MEM_ADDR_CHECK_EN
        illegal = (a < BASE) || ((off >> 2) >= DEPTH) || (a[1:0] != 2'b00);
`else
        illegal = 0;
`endif
        if (illegal) begin
            m_err = 1'b1;
            if (!w) m_rd = 32'h0;
        end else if (w) begin
            m_mem[i] = d;
        end else begin
            m_rd = m_mem[i];
        end
        e.rdata = m_rd;
        e.err   = m_err;
    endtask

    // Monitor: every response pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (mem_ready && prev_ready)
            chk("ready_one_cycle", 32'(mem_ready && prev_ready), 32'd0);
        prev_ready = mem_ready;
        if (mem_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rdata", mem_rdata, e.rdata);
                chk("err", 32'(err), 32'(e.err));
            end
        end
    end

    task automatic idle(input int k);
        mem_valid = 1'b0;
        repeat (k) begin
            @(posedge clk);
            @(negedge clk);
        end
        in_resp = 0;
    endtask

    task automatic preload(input logic [31:0] i, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_idx  = i;
        ld_data = d;
        @(posedge clk);
        m_mem[i % DEPTH] = d;
        @(negedge clk);
        ld_en   = 1'b0;
        in_resp = 0;
    endtask

    task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input bit keep);
        exp_t e;
        int   n;
        mem_valid = 1'b1;
        mem_write = w;
        mem_addr  = a;
        mem_wdata = d;
        if (in_resp) begin
            @(posedge clk);
            @(negedge clk);
        end
        @(posedge clk);
        model(w, a, d, e);
        q.push_back(e);
        #1;
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        mem_write = 1'($urandom);
        if (!keep) mem_valid = 1'b0;
        n = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_ready) break;
            @(posedge clk);
            n++;
        end
        if (!mem_ready)
            chk("ready_timeout", 32'(mem_ready), 32'd1);
        chk("latency", 32'(n), 32'(LAT));
        last_ready = cyc;
        in_resp = 1;
    endtask

    initial begin
        int t0;
        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ld_en     = 1'b0;
        ld_idx    = '0;
        ld_data   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            preload(32'(i), 32'(i) ^ 32'h5A00_0000);
        end
        repeat (2) @(negedge clk);
        chk("reset_ready", 32'(mem_ready), 32'd0);
        chk("reset_rdata", mem_rdata, 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        reset = 1'b0;
        idle(1);

        // Preload then read, rdata held afterwards.
        preload(32'd5, 32'h1234_5678);
        req(1'b0, 32'h14, 32'h0, 0);
        idle(3);
        chk("rdata_hold", mem_rdata, m_rd);

        // Write then read; write response must not disturb rdata.
        req(1'b1, 32'h40, 32'hCAFE_F00D, 0);
        req(1'b0, 32'h40, 32'h0, 0);
        idle(1);

        // Continuous valid, back-to-back reads.
        for (int i = 0; i < 4; i++) preload(32'(i), 32'(10 + i));
        for (int i = 0; i < 4; i++) begin
            t0 = last_ready;
            req(1'b0, 32'(i * 4), 32'h0, i != 3);
            if (i > 0) chk("gap", 32'(last_ready - t0), 32'(LAT + 1));
        end
        idle(2);

        // Reset during WAIT drops the write and the response.
        preload(32'd7, 32'h0000_0007);
        mem_valid = 1'b1;
        mem_write = 1'b1;
        mem_addr  = 32'h1C;
        mem_wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        mem_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_rd  = 32'h0;
        m_err = 1'b0;
        chk("rst_mid_rdata", mem_rdata, 32'd0);
        chk("rst_mid_err", 32'(err), 32'd0);
        idle(4);
        req(1'b0, 32'h1C, 32'h0, 0);
        idle(1);

        // Wrap / illegal write, then misaligned read and sticky err.
        req(1'b1, 32'h44, 32'hA5A5_A5A5, 0);
        req(1'b0, 32'h04, 32'h0, 0);
        req(1'b0, 32'h42, 32'h0, 0);
        idle(3);
        chk("err_sticky", 32'(err), 32'(m_err));

        // Randomized traffic.
        for (int it = 0; it < 80; it++) begin
            logic [31:0] a;
            if ($urandom_range(0, 3) == 0) begin
                preload($urandom, $urandom);
            end else begin
                a = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
                if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
                req(1'($urandom), a, $urandom, 0);
                if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            end
        end
        idle(5);

        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("final_err_cleared", 32'(err), 32'd0);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
